// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer for the extended-MIPS core.
// Resolves status-coded branches, including multi-cycle memory-target branches with a timeout trap.
module pc_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter int                INSN_STEP  = 4,
    parameter int                ALIGN_BITS = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] TRAP_PC    = 'h80,
    parameter int                TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [2:0]        br_op,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic [ADDR_W-1:0] reg_s,
    input  logic [ADDR_W-1:0] j_diraddr,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              mem_req,
    output logic              stall,
    output logic              taken,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_addr,
    output logic              err
);

    localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_BMN   = 3'b001;
    localparam logic [2:0] OP_BRZ   = 3'b010;
    localparam logic [2:0] OP_BZ    = 3'b011;
    localparam logic [2:0] OP_JMOR  = 3'b100;
    localparam logic [2:0] OP_JALM  = 3'b101;
    localparam logic [2:0] OP_JSPAL = 3'b110;

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [2:0]         r_op;
    logic [ADDR_W-1:0]  r_ret;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_taken;
    logic               r_linkWe;
    logic [ADDR_W-1:0]  r_linkAddr;
    logic               r_err;

    state_t             w_stateNext;
    logic [ADDR_W-1:0]  w_pcNext;
    logic [2:0]         w_opNext;
    logic [ADDR_W-1:0]  w_retNext;
    logic [CNT_W-1:0]   w_cntNext;
    logic               w_takenNext;
    logic               w_linkWeNext;
    logic [ADDR_W-1:0]  w_linkAddrNext;
    logic               w_errNext;
    logic               w_enterWait;
    logic [ADDR_W-1:0]  w_pcPlus;

    assign w_pcPlus  = r_pc + ADDR_W'(INSN_STEP);
    assign pc        = r_pc;
    assign pc_plus   = w_pcPlus;
    assign mem_req   = (r_state == ST_MEM_WAIT);
    assign stall     = (r_state == ST_MEM_WAIT);
    assign taken     = r_taken;
    assign link_we   = r_linkWe;
    assign link_addr = r_linkAddr;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_op       <= OP_NONE;
            r_ret      <= '0;
            r_cnt      <= '0;
            r_taken    <= 1'b0;
            r_linkWe   <= 1'b0;
            r_linkAddr <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_op       <= w_opNext;
            r_ret      <= w_retNext;
            r_cnt      <= w_cntNext;
            r_taken    <= w_takenNext;
            r_linkWe   <= w_linkWeNext;
            r_linkAddr <= w_linkAddrNext;
            r_err      <= w_errNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_opNext       = r_op;
        w_retNext      = r_ret;
        w_cntNext      = r_cnt;
        w_takenNext    = 1'b0;
        w_linkWeNext   = 1'b0;
        w_linkAddrNext = r_linkAddr;
        w_errNext      = r_err;
        w_enterWait    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (advance) begin
                    case (br_op)
                        OP_NONE: w_pcNext = w_pcPlus;
                        OP_BMN: begin
                            if (flag_n) w_enterWait = 1'b1;
                            else        w_pcNext    = w_pcPlus;
                        end
                        OP_BRZ: begin
                            if (flag_z) begin
                                w_pcNext    = reg_s & ALIGN_MASK;
                                w_takenNext = 1'b1;
                            end else begin
                                w_pcNext = w_pcPlus;
                            end
                        end
                        OP_BZ: begin
                            if (flag_z) begin
                                w_pcNext    = j_diraddr & ALIGN_MASK;
                                w_takenNext = 1'b1;
                            end else begin
                                w_pcNext = w_pcPlus;
                            end
                        end
                        OP_JMOR, OP_JALM, OP_JSPAL: w_enterWait = 1'b1;
                        default: begin
                            w_pcNext  = w_pcPlus;
                            w_errNext = 1'b1;
                        end
                    endcase
                end
                // The return address is captured at issue since pc_plus moves once pc redirects.
                if (w_enterWait) begin
                    w_stateNext = ST_MEM_WAIT;
                    w_opNext    = br_op;
                    w_retNext   = w_pcPlus;
                    w_cntNext   = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    w_pcNext    = mem_rdata & ALIGN_MASK;
                    w_stateNext = ST_RUN;
                    w_takenNext = 1'b1;
                    if (r_op == OP_JALM || r_op == OP_JSPAL) begin
                        w_linkWeNext   = 1'b1;
                        w_linkAddrNext = r_ret;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_pcNext    = TRAP_PC;
                    w_errNext   = 1'b1;
                    w_stateNext = ST_RUN;
                    w_takenNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequencing, direct branches,
// memory-target branches with link, timeout trap, reset mid-wait, illegal op and wrap.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        advance;
    logic [2:0]  br_op;
    logic        flag_n;
    logic        flag_z;
    logic [31:0] reg_s;
    logic [31:0] j_diraddr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        mem_req;
    logic        stall;
    logic        taken;
    logic        link_we;
    logic [31:0] link_addr;
    logic        err;

    int checks;
    int errors;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .br_op     (br_op),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .reg_s     (reg_s),
        .j_diraddr (j_diraddr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .mem_req   (mem_req),
        .stall     (stall),
        .taken     (taken),
        .link_we   (link_we),
        .link_addr (link_addr),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        advance   = 1'b0;
        br_op     = 3'b000;
        flag_n    = 1'b0;
        flag_z    = 1'b0;
        mem_ack   = 1'b0;
    endtask

    // Uses a taken bz to place the PC at a known address, then lets the taken pulse drain.
    task automatic redirectTo(input logic [31:0] addr);
        advance   = 1'b1;
        br_op     = 3'b011;
        flag_z    = 1'b1;
        j_diraddr = addr;
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        reg_s = '0; j_diraddr = '0; mem_rdata = '0;
        tick();
        tick();
        checks++;
        if (pc !== 32'h0 || mem_req !== 1'b0 || stall !== 1'b0 || taken !== 1'b0 ||
            link_we !== 1'b0 || link_addr !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got pc=%h req=%b stall=%b taken=%b lwe=%b la=%h err=%b want all zero",
                     pc, mem_req, stall, taken, link_we, link_addr, err);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] expPc;
        advance = 1'b1;
        br_op   = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            expPc = 32'(i * 4);
            checks++;
            if (pc !== expPc || taken !== 1'b0) begin
                errors++;
                $display("[TB] FAIL seq_step%0d got pc=%h taken=%b want pc=%h taken=0", i, pc, taken, expPc);
            end
        end
        idleInputs();
        tick();
        checks++;
        if (pc !== 32'h10 || pc_plus !== 32'h14) begin
            errors++;
            $display("[TB] FAIL hold_no_advance got pc=%h pc_plus=%h want 00000010 00000014", pc, pc_plus);
        end
    endtask

    task automatic test_direct_branch();
        advance = 1'b1; br_op = 3'b011; flag_z = 1'b1; j_diraddr = 32'h203;
        tick();
        checks++;
        if (pc !== 32'h200 || taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bz_taken got pc=%h taken=%b want 00000200 1", pc, taken);
        end
        idleInputs();
        tick();
        checks++;
        if (pc !== 32'h200 || taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bz_pulse_end got pc=%h taken=%b want 00000200 0", pc, taken);
        end
        redirectTo(32'h10);
        advance = 1'b1; br_op = 3'b011; flag_z = 1'b0; j_diraddr = 32'h203;
        tick();
        checks++;
        if (pc !== 32'h14 || taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bz_not_taken got pc=%h taken=%b want 00000014 0", pc, taken);
        end
        br_op = 3'b010; flag_z = 1'b1; reg_s = 32'h123;
        tick();
        checks++;
        if (pc !== 32'h120 || taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL brz_taken got pc=%h taken=%b want 00000120 1", pc, taken);
        end
        br_op = 3'b011; flag_z = 1'b1; j_diraddr = 32'h124;
        tick();
        checks++;
        if (pc !== 32'h124 || taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bz_to_pc_plus got pc=%h taken=%b want 00000124 1", pc, taken);
        end
        idleInputs();
        tick();
    endtask

    task automatic test_jalm();
        redirectTo(32'h40);
        advance = 1'b1; br_op = 3'b101;
        tick();
        idleInputs();
        advance = 1'b1; br_op = 3'b000; flag_z = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            checks++;
            if (stall !== 1'b1 || mem_req !== 1'b1 || pc !== 32'h40 || taken !== 1'b0) begin
                errors++;
                $display("[TB] FAIL jalm_wait%0d got stall=%b req=%b pc=%h taken=%b want 1 1 00000040 0",
                         w, stall, mem_req, pc, taken);
            end
            if (w == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'h1000;
            end
            tick();
        end
        idleInputs();
        checks++;
        if (stall !== 1'b0 || pc !== 32'h1000 || taken !== 1'b1 || link_we !== 1'b1 || link_addr !== 32'h44) begin
            errors++;
            $display("[TB] FAIL jalm_return got stall=%b pc=%h taken=%b lwe=%b la=%h want 0 00001000 1 1 00000044",
                     stall, pc, taken, link_we, link_addr);
        end
        tick();
        checks++;
        if (taken !== 1'b0 || link_we !== 1'b0 || pc !== 32'h1000) begin
            errors++;
            $display("[TB] FAIL jalm_pulse_end got taken=%b lwe=%b pc=%h want 0 0 00001000", taken, link_we, pc);
        end
    endtask

    task automatic test_bmn();
        redirectTo(32'h40);
        advance = 1'b1; br_op = 3'b001; flag_n = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h44 || mem_req !== 1'b0 || taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bmn_not_taken got pc=%h req=%b taken=%b want 00000044 0 0", pc, mem_req, taken);
        end
        flag_n = 1'b1;
        tick();
        idleInputs();
        checks++;
        if (mem_req !== 1'b1 || pc !== 32'h44) begin
            errors++;
            $display("[TB] FAIL bmn_enter_wait got req=%b pc=%h want 1 00000044", mem_req, pc);
        end
        mem_ack = 1'b1; mem_rdata = 32'h300;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (pc !== 32'h300 || taken !== 1'b1 || link_we !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bmn_return got pc=%h taken=%b lwe=%b req=%b want 00000300 1 0 0",
                     pc, taken, link_we, mem_req);
        end
        tick();
    endtask

    task automatic test_ack_in_timeout_cycle();
        redirectTo(32'h500);
        advance = 1'b1; br_op = 3'b100;
        tick();
        idleInputs();
        for (int w = 1; w < 15; w++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h607;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (pc !== 32'h604 || err !== 1'b0 || taken !== 1'b1 || link_we !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_beats_trap got pc=%h err=%b taken=%b lwe=%b stall=%b want 00000604 0 1 0 0",
                     pc, err, taken, link_we, stall);
        end
        tick();
    endtask

    task automatic test_timeout();
        int waitCycles;
        advance = 1'b1; br_op = 3'b100;
        tick();
        idleInputs();
        waitCycles = 0;
        while (stall === 1'b1 && waitCycles < 40) begin
            waitCycles++;
            tick();
        end
        checks++;
        if (waitCycles !== 15 || pc !== 32'h80 || err !== 1'b1 || taken !== 1'b1 || link_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_trap got waits=%0d pc=%h err=%b taken=%b lwe=%b want 15 00000080 1 1 0",
                     waitCycles, pc, err, taken, link_we);
        end
        mem_ack = 1'b1; mem_rdata = 32'h900;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (pc !== 32'h80 || err !== 1'b1 || taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_ack_ignored got pc=%h err=%b taken=%b want 00000080 1 0", pc, err, taken);
        end
        advance = 1'b1; br_op = 3'b000;
        tick();
        idleInputs();
        checks++;
        if (pc !== 32'h84 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky got pc=%h err=%b want 00000084 1", pc, err);
        end
    endtask

    task automatic test_reset_midwait();
        redirectTo(32'h40);
        advance = 1'b1; br_op = 3'b101;
        tick();
        idleInputs();
        tick();
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h2000;
        tick();
        checks++;
        if (pc !== 32'h0 || mem_req !== 1'b0 || link_we !== 1'b0 || err !== 1'b0 || taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midwait got pc=%h req=%b lwe=%b err=%b taken=%b want 00000000 0 0 0 0",
                     pc, mem_req, link_we, err, taken);
        end
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (pc !== 32'h0 || link_we !== 1'b0 || taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_after_reset got pc=%h lwe=%b taken=%b want 00000000 0 0", pc, link_we, taken);
        end
    endtask

    task automatic test_illegal_and_wrap();
        advance = 1'b1; br_op = 3'b111;
        tick();
        checks++;
        if (pc !== 32'h4 || err !== 1'b1 || taken !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_op got pc=%h err=%b taken=%b req=%b want 00000004 1 0 0",
                     pc, err, taken, mem_req);
        end
        idleInputs();
        redirectTo(32'hFFFF_FFFC);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_pc_plus got pc=%h pc_plus=%h want fffffffc 00000000", pc, pc_plus);
        end
        advance = 1'b1; br_op = 3'b000;
        tick();
        idleInputs();
        checks++;
        if (pc !== 32'h0 || taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_step got pc=%h taken=%b want 00000000 0", pc, taken);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_direct_branch();
        test_jalm();
        test_bmn();
        test_ack_in_timeout_cycle();
        test_timeout();
        test_reset_midwait();
        test_illegal_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
